// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Turns the UART RX byte stream into 32-bit instruction-memory writes and
//   holds the CPU core in reset until a full image of WORD_COUNT words has
//   been written. A gap of TIMEOUT_CYCLES between bytes mid-image abandons
//   the partial image; boot_req in DONE re-arms the loader.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   boot_req          one-cycle reboot request (acted on only in DONE)
//   mem_we/mem_addr/mem_wdata  instruction memory write port (registered)
//   loader_owns_mem   1 = loader drives the memory port, 0 = core does
//   cpu_rst_n         active-low reset to the core
//   boot_done         image complete, core released
//   timeout_err       one-cycle pulse when a partial image is abandoned
//   fsm_state         current state (0 IDLE, 1 LOAD, 2 DONE) for observation
//
// Handshake: rx_valid is a strobe with no back-pressure; every byte strobed
// in IDLE or LOAD is consumed in that cycle, one byte per cycle max.
module uart_boot_loader #(
    parameter int WORD_COUNT     = 13,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              boot_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              loader_owns_mem,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              timeout_err,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0]  GAP_MAX = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W:0]   IDX_END = (ADDR_W + 1)'(WORD_COUNT);

    state_t            state;
    logic [1:0]        lane;
    logic [23:0]       hold;
    logic [ADDR_W:0]   word_idx;
    logic [GAP_W-1:0]  gap;
    logic              take;

    assign fsm_state = state;

    // A byte is consumed in IDLE, or in LOAD while the image is not yet
    // complete (word_idx reaches IDX_END only during the final mem_we cycle,
    // and bytes in that cycle are dropped since the core is about to run).
    always_comb begin
        take = 1'b0;
        if (rx_valid) begin
            if (state == IDLE)
                take = 1'b1;
            else if (state == LOAD && word_idx != IDX_END)
                take = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            lane            <= '0;
            hold            <= '0;
            word_idx        <= '0;
            gap             <= '0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            loader_owns_mem <= 1'b1;
            cpu_rst_n       <= 1'b0;
            boot_done       <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    gap <= '0;
                    if (rx_valid)
                        state <= LOAD;
                end
                LOAD: begin
                    if (word_idx == IDX_END) begin
                        // Cycle after the last write: hand the port to the core.
                        state           <= DONE;
                        gap             <= '0;
                        loader_owns_mem <= 1'b0;
                        cpu_rst_n       <= 1'b1;
                        boot_done       <= 1'b1;
                    end else if (rx_valid) begin
                        // A byte on the boundary cycle beats the timeout.
                        gap <= '0;
                    end else if (gap == GAP_MAX) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        lane        <= '0;
                        hold        <= '0;
                        word_idx    <= '0;
                        gap         <= '0;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                DONE: begin
                    if (boot_req) begin
                        state           <= IDLE;
                        lane            <= '0;
                        hold            <= '0;
                        word_idx        <= '0;
                        gap             <= '0;
                        loader_owns_mem <= 1'b1;
                        cpu_rst_n       <= 1'b0;
                        boot_done       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Byte assembly, LSB first. Mutually exclusive with the timeout
            // and reboot clears above, which only fire without a taken byte.
            if (take) begin
                if (lane == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_idx[ADDR_W-1:0];
                    mem_wdata <= {rx_data, hold};
                    word_idx  <= word_idx + 1'b1;
                end else begin
                    hold[8*lane +: 8] <= rx_data;
                end
                lane <= lane + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: table-driven back-to-back byte vectors, then
// hand-written sequences for timeout boundary, truncated image, full images,
// ignored inputs in DONE, reboot and asynchronous reset mid-image.
module tb_uart_boot_loader;

    localparam int WC   = 13;
    localparam int AW   = 4;
    localparam int TO   = 64;
    localparam int W    = AW + 32;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          boot_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          loader_owns_mem;
    logic          cpu_rst_n;
    logic          boot_done;
    logic          timeout_err;
    logic [1:0]    fsm_state;

    uart_boot_loader #(.WORD_COUNT(WC), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .boot_req(boot_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .loader_owns_mem(loader_owns_mem),
        .cpu_rst_n(cpu_rst_n), .boot_done(boot_done),
        .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int to_count = 0;
    bit last_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of byte assembly
    int          m_lane;
    int          m_widx;
    logic [23:0] m_hold;
    bit          m_done;

    task automatic model_clear();
        m_lane = 0; m_widx = 0; m_hold = '0; m_done = 0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        logic [AW-1:0] a;
        if (m_done) return;
        if (m_lane == 3) begin
            a = AW'(m_widx);
            exp_q.push_back({a, d, m_hold});
            m_widx++;
            m_lane = 0;
            if (m_widx == WC) m_done = 1;
        end else begin
            m_hold[8*m_lane +: 8] = d;
            m_lane++;
        end
    endtask

    // Monitor: every write must match the next expected one; the core is
    // released exactly one cycle after the last write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (last_seen) begin
                check("release_cpu_rst_n", cpu_rst_n, 1);
                check("release_boot_done", boot_done, 1);
                check("release_owns_mem", loader_owns_mem, 0);
                last_seen = 0;
            end
            if (mem_we) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    check("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
                end
                check("cpu_held_during_write", cpu_rst_n, 0);
                if (mem_addr == AW'(WC - 1)) last_seen = 1;
            end
            if (timeout_err) to_count++;
        end
    end

    // ---------------- driver tasks ----------------
    // All inputs change on the falling edge; each call spans one clock.
    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        if (v) model_byte(d);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input logic [31:0] first_word);
        logic [31:0] w;
        for (int i = 0; i < WC; i++) begin
            w = (i == 0) ? first_word : $urandom;
            for (int b = 0; b < 4; b++) begin
                cycle(1'b1, w[8*b +: 8]);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("image_state_done", fsm_state, 2);
        check("image_cpu_running", cpu_rst_n, 1);
        check("image_q_drained", exp_q.size(), 0);
    endtask

    task automatic reboot();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        check("reboot_cpu_rst_n", cpu_rst_n, 0);
        check("reboot_owns_mem", loader_owns_mem, 1);
        check("reboot_boot_done", boot_done, 0);
        check("reboot_state", fsm_state, 0);
        model_clear();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_owns_mem"}, loader_owns_mem, 1);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_boot_done"}, boot_done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen_at;
        int w_before;

        vecs[0] = '{1'b1, 8'h11, 1'b0, 4'd0, 32'h0,        2'd1};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 4'd0, 32'h0,        2'd1};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 4'd0, 32'h0,        2'd1};
        vecs[3] = '{1'b1, 8'h44, 1'b1, 4'd0, 32'h44332211, 2'd1};
        vecs[4] = '{1'b1, 8'h55, 1'b0, 4'd0, 32'h44332211, 2'd1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 4'd0, 32'h44332211, 2'd1};

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; boot_req = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Back-to-back strobes from IDLE
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].valid, vecs[i].data);
            check($sformatf("vec%0d_we", i), mem_we, vecs[i].we);
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
            check($sformatf("vec%0d_state", i), fsm_state, vecs[i].st);
        end

        // 0x55 already sits in lane 0: three more bytes complete word 1
        cycle(1'b1, 8'h66);
        cycle(1'b1, 8'h77);
        cycle(1'b1, 8'h88);

        // Timeout boundary: TO idle cycles, then a byte on the hit cycle
        repeat (TO) @(negedge clk);
        cycle(1'b1, 8'h99);
        repeat (2) @(negedge clk);
        check("boundary_no_timeout", to_count, 0);
        check("boundary_state_load", fsm_state, 1);

        // Truncated image: let the gap expire
        seen_at = -1;
        for (int i = 3; i <= TO + 10; i++) begin
            @(negedge clk);
            if (timeout_err && seen_at < 0) seen_at = i;
        end
        check("timeout_latency", seen_at, TO + 1);
        check("timeout_single_pulse", to_count, 1);
        check("timeout_state_idle", fsm_state, 0);
        check("timeout_cpu_held", cpu_rst_n, 0);
        model_clear();

        // Full image from address 0
        send_image(32'h00500093);

        // Bytes in DONE are ignored
        w_before = n_writes;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i + 8'hA0));
        repeat (2) @(negedge clk);
        check("done_ignores_bytes", n_writes, w_before);

        reboot();
        send_image($urandom);

        // Asynchronous reset after 20 bytes
        reboot();
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom_range(0, 255)));
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        send_image(32'h00500093);

        check("final_q_empty", exp_q.size(), 0);
        check("final_write_count", n_writes, 46);
        check("final_timeouts", to_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time guard
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
